alu: RTL and testbench

- 8-bit registered ALU for the datapath.
- Operands A and B are sampled on every rising clock edge. The ALU computes one of eight operations selected by a 3-bit opcode and registers both the result and a 4-bit flag vector.
- The result reaches a shared bus through a tri-state output gated by an output-enable.

---
 rtl/alu.sv | 100 ++++++++++
 tb/tb_alu.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu.sv
// 8-bit registered ALU. Result and flags are registered every clock edge.
// The result drives a shared bus through a tri-state gated by in_enable_out.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [2:0]       op,
    input  logic             in_enable_out,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             add_ovf;
    logic             sub_ovf;
    logic             c_bit;
    logic             o_bit;

    // Extra MSB captures carry out for ADD and borrow (A<B) for SUB.
    assign add_full = {1'b0, in_A} + {1'b0, in_B};
    assign sub_full = {1'b0, in_A} - {1'b0, in_B};

    assign add_ovf = (in_A[WIDTH-1] == in_B[WIDTH-1]) &&
                     (add_full[WIDTH-1] != in_A[WIDTH-1]);
    assign sub_ovf = (in_A[WIDTH-1] != in_B[WIDTH-1]) &&
                     (sub_full[WIDTH-1] != in_A[WIDTH-1]);

    always_comb begin
        result_d = '0;
        c_bit    = 1'b0;
        o_bit    = 1'b0;
        flags_d  = '0;
        case (op)
            OP_ADD: begin
                result_d = add_full[WIDTH-1:0];
                c_bit    = add_full[WIDTH];
                o_bit    = add_ovf;
            end
            OP_SUB: begin
                result_d = sub_full[WIDTH-1:0];
                c_bit    = sub_full[WIDTH];
                o_bit    = sub_ovf;
            end
            OP_OR:  result_d = in_A | in_B;
            OP_AND: result_d = in_A & in_B;
            OP_NOT: result_d = ~in_A;
            OP_CMP: begin
                result_d = (in_A == in_B) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
                c_bit    = sub_full[WIDTH];
                o_bit    = sub_ovf;
            end
            OP_SHR: begin
                result_d = {1'b0, in_A[WIDTH-1:1]};
                c_bit    = in_A[0];
            end
            OP_SHL: begin
                result_d = {in_A[WIDTH-2:0], 1'b0};
                c_bit    = in_A[WIDTH-1];
            end
            default: result_d = '0;
        endcase

        // CMP reports N/Z of the subtraction, not of its 0/1 result.
        if (op == OP_CMP) begin
            flags_d = {c_bit, sub_full[WIDTH-1], o_bit, (sub_full[WIDTH-1:0] == '0)};
        end else begin
            flags_d = {c_bit, result_d[WIDTH-1], o_bit, (result_d == '0)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign out   = in_enable_out ? result_q : {WIDTH{1'bz}};
    assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu: hand-computed result/flag vectors, tri-state
// enable behaviour, and asynchronous reset.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_A;
    logic [7:0] in_B;
    logic [2:0] op;
    logic       in_enable_out;
    tri1  [7:0] out_w;
    logic [3:0] flags;

    int n_cmp;
    int n_bad;

    alu #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_A          (in_A),
        .in_B          (in_B),
        .op            (op),
        .in_enable_out (in_enable_out),
        .out           (out_w),
        .flags         (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string      tag;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] f;   // {C,N,O,Z}
    } vec_t;

    vec_t vecs[$];

    task automatic apply(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        op   = o;
        in_A = a;
        in_B = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs.push_back('{"add_03_11", 3'b000, 8'h03, 8'h11, 8'h14, 4'b0000});
        vecs.push_back('{"add_40_41", 3'b000, 8'h40, 8'h41, 8'h81, 4'b0110});
        vecs.push_back('{"add_84_81", 3'b000, 8'h84, 8'h81, 8'h05, 4'b1010});
        vecs.push_back('{"add_40_c0", 3'b000, 8'h40, 8'hC0, 8'h00, 4'b1001});
        vecs.push_back('{"sub_13_03", 3'b001, 8'h13, 8'h03, 8'h10, 4'b0000});
        vecs.push_back('{"sub_01_02", 3'b001, 8'h01, 8'h02, 8'hFF, 4'b1100});
        vecs.push_back('{"sub_83_81", 3'b001, 8'h83, 8'h81, 8'h02, 4'b0000});
        vecs.push_back('{"sub_81_81", 3'b001, 8'h81, 8'h81, 8'h00, 4'b0001});
        vecs.push_back('{"sub_03_ff", 3'b001, 8'h03, 8'hFF, 8'h04, 4'b1000});
        vecs.push_back('{"sub_01_80", 3'b001, 8'h01, 8'h80, 8'h81, 4'b1110});
        vecs.push_back('{"sub_ff_01", 3'b001, 8'hFF, 8'h01, 8'hFE, 4'b0100});
        vecs.push_back('{"sub_80_01", 3'b001, 8'h80, 8'h01, 8'h7F, 4'b0010});
        vecs.push_back('{"or_03_11",  3'b010, 8'h03, 8'h11, 8'h13, 4'b0000});
        vecs.push_back('{"and_53_11", 3'b011, 8'h53, 8'h11, 8'h11, 4'b0000});
        vecs.push_back('{"not_53",    3'b100, 8'h53, 8'h00, 8'hAC, 4'b0100});
        vecs.push_back('{"cmp_53_52", 3'b101, 8'h53, 8'h52, 8'h00, 4'b0000});
        vecs.push_back('{"cmp_53_53", 3'b101, 8'h53, 8'h53, 8'h01, 4'b0001});
        vecs.push_back('{"shr_53",    3'b110, 8'h53, 8'h00, 8'h29, 4'b1000});
        vecs.push_back('{"shl_53",    3'b111, 8'h53, 8'h00, 8'hA6, 4'b0100});

        rst_n         = 1'b0;
        in_A          = 8'h00;
        in_B          = 8'h00;
        op            = 3'b000;
        in_enable_out = 1'b1;
        #12;
        check("reset_out",   out_w, 8'h00);
        check("reset_flags", {4'h0, flags}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check({vecs[i].tag, "_out"},   out_w, vecs[i].r);
            check({vecs[i].tag, "_flags"}, {4'h0, flags}, {4'h0, vecs[i].f});
        end

        // Operand changes between edges must not disturb the registered result.
        apply(3'b000, 8'h03, 8'h11);
        #2;
        op   = 3'b100;
        in_A = 8'hF0;
        in_B = 8'h0F;
        #1;
        check("hold_out",   out_w, 8'h14);
        check("hold_flags", {4'h0, flags}, 8'h00);

        // Disabled bus floats (pulled high on this net); flags stay valid.
        in_enable_out = 1'b0;
        apply(3'b100, 8'h53, 8'h00);
        check("dis_out",   out_w, 8'hFF);
        check("dis_flags", {4'h0, flags}, 8'h04);
        #1;
        in_enable_out = 1'b1;
        #1;
        check("en_out", out_w, 8'hAC);

        // Asynchronous reset mid-cycle after a nonzero result.
        apply(3'b000, 8'h84, 8'h81);
        check("pre_rst_out", out_w, 8'h05);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out",   out_w, 8'h00);
        check("rst_flags", {4'h0, flags}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        apply(3'b000, 8'h40, 8'h41);
        check("post_rst_out",   out_w, 8'h81);
        check("post_rst_flags", {4'h0, flags}, 8'h06);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
